seg7_mux_decoder: RTL and testbench
===================================

Name: seg7_mux_decoder

Overview:
- Receive end of the multiplexed 7-segment bus that the counter drives onto uo_out: 7 segment lines plus 1 digit-select line.
- Samples the bus, waits for it to be stable, decodes each pattern back to a BCD digit and stores it per digit position.
- Used as the loopback and self-check block: another tile's uo_out is wired into this block's seg_in through ui_in or uio_in.

Parameters:
- STABLE_CYCLES, 16, number of consecutive identical synchronized samples required before a pattern is accepted (legal range 2..255).
- SEG_ACTIVE_LOW, 0, 1 means segment bits seg_in[6:0] are active-low and are inverted before decoding; the select bit seg_in[7] is never inverted.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  8  bits [6:0] = {g,f,e,d,c,b,a}; bit 7 = digit select (0 = units, 1 = tens); asynchronous to clk.
- err_clr  input  1  synchronous clear of the sticky error flag.
- digit0  output  4  last accepted units value.
- digit1  output  4  last accepted tens value.
- blank  output  2  bit n set when digit n last showed all segments off.
- update  output  1  one-cycle pulse on every accepted pattern, valid or blank.
- err  output  1  sticky flag: an undecodable pattern was accepted.

Behaviour:
- Reset (async, rst_n=0):
  - digit0 = digit1 = 0, blank = 2'b11, update = 0, err = 0.
  - Synchronizer, sample history and stability counter cleared; FSM goes to WAIT.
  - A reset asserted mid-window discards the pending pattern and produces no update.
- Synchronizer: 2 flops on all 8 seg_in bits, giving s. prev is s delayed by 1 cycle.
- Stability counter cnt:
  - Width is ceil(log2(STABLE_CYCLES+1)).
  - s != prev: cnt <= 0.
  - Otherwise cnt increments and saturates at STABLE_CYCLES.
- FSM states:
  - WAIT: when s == prev and cnt == STABLE_CYCLES-1, go to ACCEPT and latch s into pat.
  - ACCEPT: exactly 1 cycle. Decode pat, register the results, then go to HOLD.
  - HOLD: stay until s != prev, then go to WAIT with cnt = 0. A pattern is accepted at most once per stable window.
  - Any s != prev in WAIT restarts the window.
- Decode of pat[6:0], after the optional inversion (hex, active-high):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
  - 00 = blank.
  - Every other value is invalid.
- Registered results at the ACCEPT-to-HOLD edge, with n = pat[7]:
  - Valid digit: digit_n <= value, blank[n] <= 0, update <= 1.
  - Blank pattern: digit_n unchanged, blank[n] <= 1, update <= 1.
  - Invalid pattern: digit_n and blank unchanged, update stays 0, err <= 1.
- Latency: with seg_in constant from clock edge k (and different before it), update is high during the cycle following edge k+STABLE_CYCLES+3. Digit outputs change on that same edge.
- update is high for exactly 1 cycle per accept and is never high 2 cycles in a row.
- err_clr: err <= 0 on the next edge. If err_clr and a new invalid accept land on the same edge, err is set (set wins).
- Glitch rejection: a change shorter than STABLE_CYCLES samples produces no update and no error.
- Multiplexed input: a refresh period per digit of at least STABLE_CYCLES+2 clk cycles is required. Faster multiplexing yields no updates; this is not an error.

Test Plan (STABLE_CYCLES=4, SEG_ACTIVE_LOW=0 unless stated):
- Reset then idle: hold rst_n=0 for 3 cycles, release, keep seg_in=00 → digit0=digit1=0 and blank=11. One update pulse occurs when 00 on the units position is accepted; err=0.
- Hold seg_in=0x5B from edge k → update high exactly in the cycle after edge k+7, digit0=2, blank[0]=0. No second pulse while held.
- Drive 0x86 then 0xEF, each held 10 cycles → digit1 = 1 and then 9, two update pulses; digit0 unchanged.
- Drive 0x4F for 3 cycles, then 0x06 held → no update for 0x4F; a single update with digit0=1.
- Drive 0x49 held → err=1, no update, digits unchanged. Pulse err_clr → err=0. err_clr on the same edge as a fresh invalid accept → err stays 1.
- SEG_ACTIVE_LOW=1, seg_in=0x99 held → decodes as 66, digit1=4. Assert rst_n=0 at cycle k+5 of a new window → no update, outputs return to reset values.

Source files
------------

// File: rtl/seg7_mux_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_mux_decoder
// Purpose  : Receive side of a multiplexed 7-segment bus. Synchronizes the
//            bus, waits for a stable pattern, decodes it back to BCD and
//            stores it per digit position (units / tens).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_mux_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic       err_clr,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [1:0] blank,
  output logic       update,
  output logic       err
);

  localparam int unsigned        c_CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_HIT = c_CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic [7:0]         sync1_q;
  logic [7:0]         s_q;
  logic [7:0]         prev_q;
  logic [7:0]         pat_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;
  state_t             state_q;
  logic [3:0]         digit0_q;
  logic [3:0]         digit1_q;
  logic [1:0]         blank_q;
  logic               update_q;
  logic               err_q;

  logic               w_same;
  logic [6:0]         w_seg;
  logic [3:0]         w_dec_val;
  logic               w_dec_valid;
  logic               w_dec_blank;

  assign w_same = (s_q == prev_q);

  // Two-flop synchronizer on the whole bus, plus a one-cycle history copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      s_q     <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= seg_in;
      s_q     <= sync1_q;
      prev_q  <= s_q;
      cnt_q   <= cnt_d;
    end
  end

  // Stability counter: restarts on any change, saturates at STABLE_CYCLES
  always_comb begin
    cnt_d = cnt_q;
    if (!w_same) begin
      cnt_d = '0;
    end else if (cnt_q != c_CNT_MAX) begin
      cnt_d = cnt_q + c_CNT_W'(1);
    end
  end

  // Segment polarity is fixed at build time; the select bit is never inverted
  generate
    if (SEG_ACTIVE_LOW) begin : g_active_low
      assign w_seg = ~pat_q[6:0];
    end else begin : g_active_high
      assign w_seg = pat_q[6:0];
    end
  endgenerate

  // Pattern decoder {g,f,e,d,c,b,a} -> BCD, blank or invalid
  always_comb begin
    w_dec_val   = 4'd0;
    w_dec_valid = 1'b1;
    w_dec_blank = 1'b0;
    case (w_seg)
      7'h3F: w_dec_val = 4'd0;
      7'h06: w_dec_val = 4'd1;
      7'h5B: w_dec_val = 4'd2;
      7'h4F: w_dec_val = 4'd3;
      7'h66: w_dec_val = 4'd4;
      7'h6D: w_dec_val = 4'd5;
      7'h7D: w_dec_val = 4'd6;
      7'h07: w_dec_val = 4'd7;
      7'h7F: w_dec_val = 4'd8;
      7'h6F: w_dec_val = 4'd9;
      7'h00: begin
        w_dec_valid = 1'b0;
        w_dec_blank = 1'b1;
      end
      default: w_dec_valid = 1'b0;
    endcase
  end

  // Accept FSM with registered results; one accept per stable window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT;
      pat_q    <= '0;
      digit0_q <= 4'd0;
      digit1_q <= 4'd0;
      blank_q  <= 2'b11;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        ST_WAIT: begin
          if (w_same && (cnt_q == c_CNT_HIT)) begin
            pat_q   <= s_q;
            state_q <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          state_q <= ST_HOLD;
          if (w_dec_valid) begin
            if (pat_q[7]) begin
              digit1_q <= w_dec_val;
            end else begin
              digit0_q <= w_dec_val;
            end
            blank_q[pat_q[7]] <= 1'b0;
            update_q          <= 1'b1;
          end else if (w_dec_blank) begin
            blank_q[pat_q[7]] <= 1'b1;
            update_q          <= 1'b1;
          end else begin
            // A new error outranks a simultaneous clear
            err_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!w_same) begin
            state_q <= ST_WAIT;
          end
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign digit0 = digit0_q;
  assign digit1 = digit1_q;
  assign blank  = blank_q;
  assign update = update_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_mux_decoder
// Purpose  : Scoreboard bench for seg7_mux_decoder (active-high and
//            active-low instances, STABLE_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_mux_decoder;

  localparam int unsigned ST = 4;

  logic       clk = 1'b0;
  logic       rst_n_a, rst_n_b;
  logic       err_clr_a, err_clr_b;
  logic [7:0] seg_a, seg_b;
  logic [3:0] d0_a, d1_a, d0_b, d1_b;
  logic [1:0] bl_a, bl_b;
  logic       upd_a, upd_b, err_a, err_b;

  seg7_mux_decoder #(.STABLE_CYCLES(ST), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .seg_in(seg_a), .err_clr(err_clr_a),
    .digit0(d0_a), .digit1(d1_a), .blank(bl_a), .update(upd_a), .err(err_a)
  );

  seg7_mux_decoder #(.STABLE_CYCLES(ST), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .seg_in(seg_b), .err_clr(err_clr_b),
    .digit0(d0_b), .digit1(d1_b), .blank(bl_b), .update(upd_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] bl;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor A: every update must match the oldest pending expectation
  logic upd_a_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (upd_a === 1'b1) begin
      check("a_update_one_cycle", 32'(upd_a_prev), 32'd0);
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_update: update=1 at cycle %0d, expected no update", cyc);
      end else begin
        e = q_a.pop_front();
        if (e.cyc >= 0) check("a_update_cycle", 32'(cyc), 32'(e.cyc));
        check("a_digit0", 32'(d0_a), 32'(e.d0));
        check("a_digit1", 32'(d1_a), 32'(e.d1));
        check("a_blank", 32'(bl_a), 32'(e.bl));
      end
    end
    upd_a_prev <= upd_a;
  end

  // Monitor B: same for the active-low instance
  logic upd_b_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (upd_b === 1'b1) begin
      check("b_update_one_cycle", 32'(upd_b_prev), 32'd0);
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_update: update=1 at cycle %0d, expected no update", cyc);
      end else begin
        e = q_b.pop_front();
        if (e.cyc >= 0) check("b_update_cycle", 32'(cyc), 32'(e.cyc));
        check("b_digit0", 32'(d0_b), 32'(e.d0));
        check("b_digit1", 32'(d1_b), 32'(e.d1));
        check("b_blank", 32'(bl_b), 32'(e.bl));
      end
    end
    upd_b_prev <= upd_b;
  end

  function automatic void push_a(input int c, input logic [3:0] d0, input logic [3:0] d1,
                                 input logic [1:0] bl);
    exp_t e;
    e.cyc = c; e.d0 = d0; e.d1 = d1; e.bl = bl;
    q_a.push_back(e);
  endfunction

  function automatic void push_b(input int c, input logic [3:0] d0, input logic [3:0] d1,
                                 input logic [1:0] bl);
    exp_t e;
    e.cyc = c; e.d0 = d0; e.d1 = d1; e.bl = bl;
    q_b.push_back(e);
  endfunction

  // Drive a new bus value; it is first sampled at edge c+1, update expected at cycle c+8
  task automatic drive_a(input logic [7:0] v, output int c);
    @(negedge clk);
    seg_a = v;
    c = cyc;
  endtask

  task automatic drive_b(input logic [7:0] v, output int c);
    @(negedge clk);
    seg_b = v;
    c = cyc;
  endtask

  initial begin
    int c;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    err_clr_a = 1'b0; err_clr_b = 1'b0;
    seg_a = 8'h00; seg_b = 8'hFF;

    // ---------------- instance A: active-high ----------------
    repeat (3) @(negedge clk);
    check("a_reset_state", 32'({d1_a, d0_a, bl_a, upd_a, err_a}), 32'({4'd0, 4'd0, 2'b11, 1'b0, 1'b0}));
    push_a(-1, 4'd0, 4'd0, 2'b11);
    rst_n_a = 1'b1;
    repeat (12) @(negedge clk);
    check("a_idle_err", 32'(err_a), 32'd0);
    check("a_idle_drained", 32'(q_a.size()), 32'd0);

    // 0x5B on units -> 2, exact latency, no repeat while held
    drive_a(8'h5B, c);
    push_a(c + 8, 4'd2, 4'd0, 2'b10);
    repeat (20) @(negedge clk);
    check("a_5B_drained", 32'(q_a.size()), 32'd0);

    // tens: 0x86 -> 1, then 0xEF -> 9, each held 10 cycles
    drive_a(8'h86, c);
    push_a(c + 8, 4'd2, 4'd1, 2'b00);
    repeat (9) @(negedge clk);
    drive_a(8'hEF, c);
    push_a(c + 8, 4'd2, 4'd9, 2'b00);
    repeat (15) @(negedge clk);

    // 3-cycle glitch of 0x4F is rejected, then 0x06 accepted once
    drive_a(8'h4F, c);
    repeat (2) @(negedge clk);
    drive_a(8'h06, c);
    push_a(c + 8, 4'd1, 4'd9, 2'b00);
    repeat (20) @(negedge clk);
    check("a_glitch_drained", 32'(q_a.size()), 32'd0);
    check("a_glitch_no_err", 32'(err_a), 32'd0);

    // invalid 0x49 sets err, leaves digits alone
    drive_a(8'h49, c);
    repeat (15) @(negedge clk);
    check("a_invalid_err", 32'(err_a), 32'd1);
    check("a_invalid_keep", 32'({d1_a, d0_a, bl_a}), 32'({4'd9, 4'd1, 2'b00}));
    err_clr_a = 1'b1;
    @(negedge clk);
    err_clr_a = 1'b0;
    check("a_err_cleared", 32'(err_a), 32'd0);

    // err_clr on the same edge as a fresh invalid accept: set wins
    drive_a(8'h4A, c);
    repeat (7) @(negedge clk);
    check("a_err_before_set", 32'(err_a), 32'd0);
    err_clr_a = 1'b1;
    @(negedge clk);
    err_clr_a = 1'b0;
    check("a_err_set_wins", 32'(err_a), 32'd1);
    repeat (5) @(negedge clk);
    check("a_final_drained", 32'(q_a.size()), 32'd0);

    // ---------------- instance B: active-low ----------------
    check("b_reset_state", 32'({d1_b, d0_b, bl_b, upd_b, err_b}), 32'({4'd0, 4'd0, 2'b11, 1'b0, 1'b0}));
    push_b(-1, 4'd0, 4'd0, 2'b11);
    rst_n_b = 1'b1;
    repeat (15) @(negedge clk);
    check("b_idle_drained", 32'(q_b.size()), 32'd0);

    // 0x99 active-low -> 0x66 on tens -> 4
    drive_b(8'h99, c);
    push_b(c + 8, 4'd0, 4'd4, 2'b01);
    repeat (15) @(negedge clk);
    check("b_99_drained", 32'(q_b.size()), 32'd0);

    // reset mid-window discards the pending 0xB0 (would decode to 3)
    drive_b(8'hB0, c);
    repeat (5) @(negedge clk);
    rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    check("b_midreset_state", 32'({d1_b, d0_b, bl_b, upd_b, err_b}), 32'({4'd0, 4'd0, 2'b11, 1'b0, 1'b0}));
    check("b_midreset_no_update", 32'(q_b.size()), 32'd0);
    push_b(-1, 4'd0, 4'd3, 2'b01);
    rst_n_b = 1'b1;
    repeat (20) @(negedge clk);
    check("b_final_drained", 32'(q_b.size()), 32'd0);
    check("b_final_err", 32'(err_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
